// File: rtl/riscv_trace_pkg.sv
// riscv_trace_pkg: shared definitions for the RISC-V trace capture block.
//   - serializer state encoding
//   - bit positions inside the 32-bit flags word
//   - trace record layout and width (96 bits, or 128 with timestamp)
// Build option: RISCV_TRACE_TIMESTAMP_EN adds a 32-bit cycle timestamp per record.
package riscv_trace_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_W_PC    = 3'd1,
    ST_W_INSTR = 3'd2,
    ST_W_FLAGS = 3'd3,
    ST_W_TS    = 3'd4
  } ser_state_t;

  localparam int BR_LSB     = 0;
  localparam int CTL_LSB    = 5;
  localparam int ALU_LSB    = 10;
  localparam int TS_FMT_BIT = 16;
  localparam int SEQ_LSB    = 24;

`ifdef RISCV_TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
  localparam int REC_W = 128;
`else
  localparam bit TS_EN = 1'b0;
  localparam int REC_W = 96;
`endif

  typedef struct packed {
`ifdef RISCV_TRACE_TIMESTAMP_EN
    logic [31:0] ts;
`endif
    logic [31:0] flags;
    logic [31:0] instr;
    logic [31:0] pc;
  } trace_rec_t;

endpackage

// File: rtl/riscv_trace_capture_if.sv
// riscv_trace_capture_if: 32-bit valid/ready trace word stream.
//   m_data  : trace word
//   m_valid : word valid
//   m_ready : sink accepts word
//   m_last  : final word of a record
// master = trace capture block, slave = trace drain (UART/JTAG).
interface riscv_trace_capture_if;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/riscv_trace_fifo.sv
// riscv_trace_fifo: synchronous FIFO for trace records.
//   clk, reset   : clock, synchronous active-high reset
//   push, wdata  : write side (ignored while full)
//   pop, rdata   : read side; rdata shows the head entry (ignored while empty)
//   full, empty  : status
//   level        : entries held
// Push and pop in the same cycle are both honoured.
module riscv_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level = wr_ptr - rd_ptr;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end
endmodule

// File: rtl/riscv_trace_capture.sv
// riscv_trace_capture: captures each new core instruction (pc change) as a
// trace record, buffers it, and streams it out as 32-bit words.
//   clk, reset    : clock, synchronous active-high reset
//   trace_en      : capture enable
//   clr_ovf       : clears overflow and drop_cnt
//   pc_in, instr_in, alu_ctrl_in, br_flags_in, ctl_flags_in : core observation
//   m             : trace word stream (master), words pc, instr, flags[, ts]
//   overflow      : sticky "a record was dropped"
//   drop_cnt      : dropped-record count, saturating
//   fifo_level    : records held in the FIFO (not counting the one being sent)
// Build option: RISCV_TRACE_TIMESTAMP_EN adds a cycle-count word after flags.
//
// Serializer states:
//   ST_IDLE    | nothing to send, waiting for FIFO data
//   ST_W_PC    | presenting pc word
//   ST_W_INSTR | presenting instr word
//   ST_W_FLAGS | presenting flags word (last word unless timestamped)
//   ST_W_TS    | presenting timestamp word (timestamp build only, last word)
module riscv_trace_capture
  import riscv_trace_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DROP_CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          trace_en,
  input  logic                          clr_ovf,
  input  logic [31:0]                   pc_in,
  input  logic [31:0]                   instr_in,
  input  logic [5:0]                    alu_ctrl_in,
  input  logic [4:0]                    br_flags_in,
  input  logic [4:0]                    ctl_flags_in,
  riscv_trace_capture_if.master         m,
  output logic                          overflow,
  output logic [DROP_CNT_W-1:0]         drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  logic [31:0]    last_pc;
  logic           have_last;
  logic [7:0]     seq;
  logic           capture;
  logic           push;
  logic           drop;
  logic           pop;
  logic           fifo_full;
  logic           fifo_empty;
  trace_rec_t     wr_rec;
  trace_rec_t     rd_rec;
  logic [REC_W-1:0] rd_data;

  ser_state_t     state;
  logic [31:0]    data_q;
  logic           valid_q;
  logic           last_q;
  logic [31:0]    hold_instr;
  logic [31:0]    hold_flags;
  logic           hs;
`ifdef RISCV_TRACE_TIMESTAMP_EN
  logic [31:0]    cyc_cnt;
  logic [31:0]    hold_ts;
  localparam ser_state_t LAST_ST = ST_W_TS;
`else
  localparam ser_state_t LAST_ST = ST_W_FLAGS;
`endif

  // ---------------- capture ----------------
  assign capture = trace_en && (!have_last || (pc_in != last_pc));
  // Fullness is judged before any same-cycle pop, so a full FIFO always drops.
  assign drop    = capture && fifo_full;
  assign push    = capture && !fifo_full;

  always_comb begin
    wr_rec                       = '0;
    wr_rec.pc                    = pc_in;
    wr_rec.instr                 = instr_in;
    wr_rec.flags[BR_LSB +: 5]    = br_flags_in;
    wr_rec.flags[CTL_LSB +: 5]   = ctl_flags_in;
    wr_rec.flags[ALU_LSB +: 6]   = alu_ctrl_in;
    wr_rec.flags[TS_FMT_BIT]     = TS_EN;
    wr_rec.flags[SEQ_LSB +: 8]   = seq;
`ifdef RISCV_TRACE_TIMESTAMP_EN
    wr_rec.ts                    = cyc_cnt;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_pc   <= '0;
      have_last <= 1'b0;
      seq       <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      have_last <= trace_en;
      if (trace_en) begin
        last_pc <= pc_in;
      end
      // seq advances on dropped records too, leaving a visible gap.
      if (capture) begin
        seq <= seq + 8'd1;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (clr_ovf) begin
          drop_cnt <= DROP_CNT_W'(1);
        end else if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
      end else if (clr_ovf) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

`ifdef RISCV_TRACE_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end
`endif

  riscv_trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wr_rec),
    .pop   (pop),
    .rdata (rd_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign rd_rec = trace_rec_t'(rd_data);

  // ---------------- serializer ----------------
  assign hs  = valid_q && m.m_ready;
  // Pop when idle, or when the last word is accepted so records run back to back.
  assign pop = !fifo_empty && ((state == ST_IDLE) || ((state == LAST_ST) && hs));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      hold_instr <= '0;
      hold_flags <= '0;
`ifdef RISCV_TRACE_TIMESTAMP_EN
      hold_ts    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: ;
        ST_W_PC: begin
          if (hs) begin
            data_q <= hold_instr;
            state  <= ST_W_INSTR;
          end
        end
        ST_W_INSTR: begin
          if (hs) begin
            data_q <= hold_flags;
            last_q <= !TS_EN;
            state  <= ST_W_FLAGS;
          end
        end
`ifdef RISCV_TRACE_TIMESTAMP_EN
        ST_W_FLAGS: begin
          if (hs) begin
            data_q <= hold_ts;
            last_q <= 1'b1;
            state  <= ST_W_TS;
          end
        end
        ST_W_TS: begin
          if (hs) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            state   <= ST_IDLE;
          end
        end
`else
        ST_W_FLAGS: begin
          if (hs) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            state   <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase

      // A pop overrides the record-complete update above.
      if (pop) begin
        data_q     <= rd_rec.pc;
        valid_q    <= 1'b1;
        last_q     <= 1'b0;
        hold_instr <= rd_rec.instr;
        hold_flags <= rd_rec.flags;
`ifdef RISCV_TRACE_TIMESTAMP_EN
        hold_ts    <= rd_rec.ts;
`endif
        state      <= ST_W_PC;
      end
    end
  end

  assign m.m_data  = data_q;
  assign m.m_valid = valid_q;
  assign m.m_last  = last_q;

endmodule
